scsi_port_cycle: RTL and testbench
==================================

# scsi_port_cycle

Bus-cycle sequencer for SDMAC port 0 (WD33C93A SCSI controller), directly downstream of the CPU address decoder. It takes the decoded, already-qualified port 0 chip select `_CSS` and turns it into timed `_IOR`/`_IOW` strobes toward the WD33C93A. It also drives the data-path controls (`DOE`, `LE`) and answers the CPU with an 8-bit-port `_DSACK` termination. One cycle is serviced at a time, with a guaranteed recovery gap between cycles.

## Interface
- `SETUP_CYC`, default 1: SCLK cycles from cycle accept to strobe assert (≥1)
- `STROBE_CYC`, default 4: SCLK cycles `_IOR`/`_IOW` held low (≥1)
- `RECOVERY_CYC`, default 2: SCLK cycles of enforced idle after each cycle ends (≥1)

Ports (all inputs synchronous to SCLK; no internal synchronisers):
- `SCLK` in 1: CPU clock. Single clock domain.
- `RST` in 1: reset, asynchronous, active-high.
- `_CSS` in 1: port 0 select from the decoder, active-low. Already includes `_CS`/`_AS`.
- `_DS` in 1: CPU data strobe, active-low.
- `R_W` in 1: CPU direction; 1 = read.
- `_IOR` out 1: WD33C93A read strobe, active-low.
- `_IOW` out 1: WD33C93A write strobe, active-low.
- `DOE` out 1: drive CPU write data onto the peripheral data bus, active-high.
- `LE` out 1: latch peripheral read data for the CPU, single-cycle pulse, active-high.
- `_DSACK` out 2: `{DSACK1,DSACK0}` termination, active-low. 2'b10 = 8-bit port ack.

## Operation
States: IDLE, SETUP, STROBE, ACK, RECOVER. A shared down-counter times SETUP, STROBE and RECOVER.

- **IDLE**
  - Accept when `_CSS`=0 and `_DS`=0 at a rising edge.
  - Latch `R_W` into `rw_q`, load counter with SETUP_CYC, go to SETUP.
- **SETUP**
  - `DOE`=1 if write.
  - On counter expiry, load STROBE_CYC and go to STROBE.
- **STROBE**
  - `_IOR`=0 if read, else `_IOW`=0. `DOE` stays 1 for writes.
  - Read: `LE`=1 only in the last STROBE cycle.
  - On expiry, go to ACK.
- **ACK**
  - Strobes high, `DOE`=0, `_DSACK`=2'b10.
  - Hold until `_CSS`=1 is sampled, then load RECOVERY_CYC and go to RECOVER.
- **RECOVER**
  - All outputs idle. `_CSS` is ignored.
  - On expiry, go to IDLE. A still-low `_CSS`/`_DS` at that point starts a new cycle on the next edge.
- **Abort:** `_CSS`=1 sampled in SETUP or STROBE goes straight to RECOVER. Strobe, `DOE` and `LE` deassert at that edge, `_DSACK` is never asserted, and no read data is latched.
- **Idle output values** (also the reset values, reached asynchronously on `RST`, and forced back on reset mid-cycle with no partial strobe): `_IOR`=1, `_IOW`=1, `DOE`=0, `LE`=0, `_DSACK`=2'b11, state IDLE, counter 0.
- `_IOR` and `_IOW` are never low simultaneously. `rw_q` is frozen for the whole cycle, so an `R_W` change mid-cycle has no effect.
- **Counter:** width `$clog2(max(SETUP_CYC,STROBE_CYC,RECOVERY_CYC)+1)`. Loads N, expires when it reaches 1. No wrap is possible.

## Timing
- All outputs are registered; none is combinational from inputs.
- Accept edge = E.
  - `DOE` (write) asserts after E.
  - Strobe asserts after E+SETUP_CYC, deasserts after E+SETUP_CYC+STROBE_CYC.
  - `LE` is high during the cycle ending at E+SETUP_CYC+STROBE_CYC.
  - `_DSACK` asserts after E+SETUP_CYC+STROBE_CYC.
- With defaults: strobe low cycles 2–5, `_DSACK` from cycle 6, minimum CPU cycle 6 clocks + ack.
- `_DSACK` deasserts at the first edge sampling `_CSS`=1. Earliest next accept is RECOVERY_CYC+1 edges later.

## Structure
- Package `sdmac_pkg`:
  - state enum `port_state_t`
  - `DSACK_BYTE` = 2'b10, `DSACK_NONE` = 2'b11
  - default timing constants
- Sub-module `cycle_timer`: loadable down-counter with `load`, `value`, `expired` and the width rule above.

## Test plan
- **Read, defaults:** `_CSS`=`_DS`=0, `R_W`=1 at edge 0 → `_IOR` low edges 2–5, `LE`=1 only in cycle 5, `_DSACK`=2'b10 from edge 6 until `_CSS`=1, `_IOW` stays 1.
- **Write, defaults:** same with `R_W`=0 → `DOE`=1 edges 1–5, `_IOW` low edges 2–5, `LE` never 1, `_DSACK`=2'b10 from edge 6.
- **Abort:** `_CSS`→1 during STROBE cycle 3 → strobe high next edge, `_DSACK` stays 2'b11, RECOVER 2 cycles, then IDLE.
- **Back-to-back:** `_CSS` released one clock after ack and reasserted immediately → new strobe not before RECOVERY_CYC+1+SETUP_CYC edges after release.
- **Reset mid-strobe:** `RST`=1 asynchronously while `_IOW`=0 → all outputs at idle values without waiting for a clock edge. After release, no cycle starts until `_CSS`/`_DS` are freshly sampled low.
- **Parameter sweep:** SETUP_CYC=3, STROBE_CYC=1, RECOVERY_CYC=1 → strobe exactly 1 cycle at edge 4, `LE` in that same cycle for a read, `_DSACK` from edge 5.

Source files
------------

// File: rtl/sdmac_pkg.sv
// Shared types and timing constants for the SDMAC port 0 bus-cycle sequencer.
package sdmac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    ACK,
    RECOVER
  } port_state_t;

  localparam logic [1:0] DSACK_BYTE = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  localparam int DEF_SETUP_CYC    = 1;
  localparam int DEF_STROBE_CYC   = 4;
  localparam int DEF_RECOVERY_CYC = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Wide enough to hold the largest load value without wrap.
  function automatic int cnt_width(input int s, input int t, input int r);
    return $clog2(max3(s, t, r) + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that times the SETUP, STROBE and RECOVER phases.
module cycle_timer
  import sdmac_pkg::*;
#(
  parameter int W = cnt_width(DEF_SETUP_CYC, DEF_STROBE_CYC, DEF_RECOVERY_CYC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Counts down to zero and parks there; a load always wins.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign expired = (value_q == W'(1));

endmodule

// File: rtl/scsi_port_cycle.sv
// SDMAC port 0 bus-cycle sequencer: turns the decoded WD33C93A select into
// timed _IOR/_IOW strobes, data-path controls and an 8-bit _DSACK termination.
module scsi_port_cycle
  import sdmac_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int RECOVERY_CYC = DEF_RECOVERY_CYC
) (
  input  logic       SCLK,
  input  logic       RST,
  input  logic       _CSS,
  input  logic       _DS,
  input  logic       R_W,
  output logic       _IOR,
  output logic       _IOW,
  output logic       DOE,
  output logic       LE,
  output logic [1:0] _DSACK
);

  localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, RECOVERY_CYC);

  port_state_t state_q, state_d;
  logic        rw_q, rw_d;
  logic        ior_q, ior_d;
  logic        iow_q, iow_d;
  logic        doe_q, doe_d;
  logic        le_q, le_d;
  logic [1:0]  dsack_q, dsack_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_expired;
  logic             strobe_next;
  logic             last_strobe;

  cycle_timer #(.W(CNT_W)) u_timer (
    .clk       (SCLK),
    .rst       (RST),
    .load      (timer_load),
    .load_value(timer_val),
    .value     (cnt_value),
    .expired   (cnt_expired)
  );

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    timer_load = 1'b0;
    timer_val  = '0;

    // A released select during SETUP/STROBE aborts ahead of any expiry.
    unique case (state_q)
      IDLE: begin
        if (!_CSS && !_DS) begin
          rw_d       = R_W;
          state_d    = SETUP;
          timer_load = 1'b1;
          timer_val  = CNT_W'(SETUP_CYC);
        end
      end
      SETUP: begin
        if (_CSS) begin
          state_d    = RECOVER;
          timer_load = 1'b1;
          timer_val  = CNT_W'(RECOVERY_CYC);
        end else if (cnt_expired) begin
          state_d    = STROBE;
          timer_load = 1'b1;
          timer_val  = CNT_W'(STROBE_CYC);
        end
      end
      STROBE: begin
        if (_CSS) begin
          state_d    = RECOVER;
          timer_load = 1'b1;
          timer_val  = CNT_W'(RECOVERY_CYC);
        end else if (cnt_expired) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (_CSS) begin
          state_d    = RECOVER;
          timer_load = 1'b1;
          timer_val  = CNT_W'(RECOVERY_CYC);
        end
      end
      RECOVER: begin
        if (cnt_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge.
    strobe_next = (state_d == STROBE);
    last_strobe = timer_load ? (timer_val == CNT_W'(1)) : (cnt_value == CNT_W'(2));

    ior_d   = ~(strobe_next && rw_d);
    iow_d   = ~(strobe_next && !rw_d);
    doe_d   = !rw_d && ((state_d == SETUP) || strobe_next);
    le_d    = strobe_next && rw_d && last_strobe;
    dsack_d = (state_d == ACK) ? DSACK_BYTE : DSACK_NONE;
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      doe_q   <= 1'b0;
      le_q    <= 1'b0;
      dsack_q <= DSACK_NONE;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      ior_q   <= ior_d;
      iow_q   <= iow_d;
      doe_q   <= doe_d;
      le_q    <= le_d;
      dsack_q <= dsack_d;
    end
  end

  assign _IOR   = ior_q;
  assign _IOW   = iow_q;
  assign DOE    = doe_q;
  assign LE     = le_q;
  assign _DSACK = dsack_q;

endmodule

// File: tb/tb_scsi_port_cycle.sv
// Directed scoreboard bench for scsi_port_cycle: default timing on one instance,
// a SETUP=3/STROBE=1/RECOVERY=1 sweep on a second.
module tb_scsi_port_cycle;

  logic SCLK = 1'b0;
  logic RST  = 1'b0;

  logic       css_a = 1'b1, ds_a = 1'b1, rw_a = 1'b1;
  logic       ior_a, iow_a, doe_a, le_a;
  logic [1:0] dsack_a;

  logic       css_b = 1'b1, ds_b = 1'b1, rw_b = 1'b1;
  logic       ior_b, iow_b, doe_b, le_b;
  logic [1:0] dsack_b;

  int checks   = 0;
  int failures = 0;

  // Packed as {_IOR, _IOW, DOE, LE, _DSACK[1:0]}
  logic [5:0] exp_q[$];
  localparam logic [5:0] IDLE_V = 6'b110011;

  always #5 SCLK = ~SCLK;

  scsi_port_cycle u_dut_a (
    .SCLK  (SCLK),
    .RST   (RST),
    ._CSS  (css_a),
    ._DS   (ds_a),
    .R_W   (rw_a),
    ._IOR  (ior_a),
    ._IOW  (iow_a),
    .DOE   (doe_a),
    .LE    (le_a),
    ._DSACK(dsack_a)
  );

  scsi_port_cycle #(
    .SETUP_CYC   (3),
    .STROBE_CYC  (1),
    .RECOVERY_CYC(1)
  ) u_dut_b (
    .SCLK  (SCLK),
    .RST   (RST),
    ._CSS  (css_b),
    ._DS   (ds_b),
    .R_W   (rw_b),
    ._IOR  (ior_b),
    ._IOW  (iow_b),
    .DOE   (doe_b),
    .LE    (le_b),
    ._DSACK(dsack_b)
  );

  // Expected outputs k edges after the accept edge, from the cycle timing rules.
  function automatic logic [5:0] exp_vec(input int k, input bit rw, input int s, input int t);
    logic       ior = 1'b1;
    logic       iow = 1'b1;
    logic       doe = 1'b0;
    logic       le  = 1'b0;
    logic [1:0] ds  = 2'b11;
    if (!rw && k < s + t) doe = 1'b1;
    if (k >= s && k < s + t) begin
      if (rw) ior = 1'b0;
      else    iow = 1'b0;
    end
    if (rw && k == s + t - 1) le = 1'b1;
    if (k >= s + t) ds = 2'b10;
    return {ior, iow, doe, le, ds};
  endfunction

  function automatic logic [5:0] observed(input int sel);
    if (sel == 0) return {ior_a, iow_a, doe_a, le_a, dsack_a};
    return {ior_b, iow_b, doe_b, le_b, dsack_b};
  endfunction

  task automatic applyStimulus(input int sel, input logic css, input logic ds, input logic rw);
    if (sel == 0) begin
      css_a = css; ds_a = ds; rw_a = rw;
    end else begin
      css_b = css; ds_b = ds; rw_b = rw;
    end
  endtask

  task automatic pushTxn(input int first_k, input int last_k, input bit rw, input int s, input int t);
    for (int k = first_k; k <= last_k; k++) exp_q.push_back(exp_vec(k, rw, s, t));
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(IDLE_V);
  endtask

  task automatic step();
    @(posedge SCLK);
    #1;
  endtask

  task automatic checkOutput(input int sel, input string tag);
    logic [5:0] o;
    logic [5:0] e;
    o = observed(sel);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=<scoreboard empty>", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        failures++;
        $error("[TB] FAIL %s observed=%b expected=%b", tag, o, e);
      end
    end
  endtask

  task automatic runChecks(input int sel, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checkOutput(sel, $sformatf("%s_%0d", tag, i));
    end
  endtask

  initial begin
    #1 RST = 1'b1;
    #1;
    pushIdle(2);
    checkOutput(0, "reset_a");
    checkOutput(1, "reset_b");
    repeat (2) @(posedge SCLK);
    #1 RST = 1'b0;

    $display("[TB] read, default timing");
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    pushTxn(0, 6, 1'b1, 1, 4);
    for (int k = 0; k <= 6; k++) begin
      step();
      checkOutput(0, $sformatf("read_k%0d", k));
      if (k == 1) rw_a = 1'b0;
    end
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    pushIdle(3);
    runChecks(0, "read_release", 3);

    $display("[TB] write, default timing");
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    pushTxn(0, 6, 1'b0, 1, 4);
    runChecks(0, "write", 7);

    $display("[TB] back-to-back after one-clock release");
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    pushIdle(1);
    runChecks(0, "b2b_release", 1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    pushIdle(2);
    pushTxn(0, 2, 1'b1, 1, 4);
    runChecks(0, "b2b", 5);

    $display("[TB] abort in strobe, then recovery length");
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    pushIdle(1);
    runChecks(0, "abort_edge", 1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    pushIdle(2);
    pushTxn(0, 1, 1'b0, 1, 4);
    runChecks(0, "abort_recover", 4);

    $display("[TB] asynchronous reset while _IOW low");
    #2 RST = 1'b1;
    #1;
    pushIdle(1);
    checkOutput(0, "reset_async");
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    #2 RST = 1'b0;
    pushIdle(2);
    runChecks(0, "post_reset", 2);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    pushTxn(0, 1, 1'b0, 1, 4);
    runChecks(0, "post_reset_write", 2);
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    pushIdle(1);
    runChecks(0, "post_reset_abort", 1);

    $display("[TB] parameter sweep SETUP=3 STROBE=1 RECOVERY=1");
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    pushTxn(0, 5, 1'b1, 3, 1);
    runChecks(1, "sweep_read", 6);
    applyStimulus(1, 1'b1, 1'b1, 1'b1);
    pushIdle(2);
    runChecks(1, "sweep_release", 2);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    pushTxn(0, 4, 1'b0, 3, 1);
    runChecks(1, "sweep_write", 5);
    applyStimulus(1, 1'b1, 1'b1, 1'b1);
    pushIdle(1);
    runChecks(1, "sweep_end", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
